// File: rtl/reg_file_32x32.sv
// MIPS register file: 32 x DATA_W storage, one synchronous write port, two combinational
// read ports built from per-bit 32:1 slices, r0 hardwired to zero, optional write->read bypass.

module reg_file_32x32_mux32to1 (
   input  logic [31:0] d,
   input  logic [4:0]  sel,
   output logic        y
);
   assign y = d[sel];
endmodule

module reg_file_32x32 #(
   parameter int DATA_W = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_addr_a,
   input  logic [4:0]        rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b
);

   // r0 has no storage at all; its column inputs are tied low below
   logic [DATA_W-1:0]        regs [1:31];
   logic [31:0]              wr_sel;
   logic [DATA_W-1:0][31:0]  col;
   logic [DATA_W-1:0]        mux_a, mux_b;
   logic                     byp_ok, hit_a, hit_b;

   // One-hot decode gated by wr_en, so an unknown wr_addr while idle selects nothing
   always_comb begin
      wr_sel = '0;
      for (int r = 1; r < 32; r++)
         wr_sel[r] = wr_en && (wr_addr == 5'(r));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r < 32; r++) regs[r] <= '0;
      end else begin
         for (int r = 1; r < 32; r++)
            if (wr_sel[r]) regs[r] <= wr_data;
      end
   end

   always_comb begin
      col = '0;
      for (int i = 0; i < DATA_W; i++)
         for (int r = 1; r < 32; r++)
            col[i][r] = regs[r][i];
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_slice
      reg_file_32x32_mux32to1 u_mux_a (.d(col[i]), .sel(rd_addr_a), .y(mux_a[i]));
      reg_file_32x32_mux32to1 u_mux_b (.d(col[i]), .sel(rd_addr_b), .y(mux_b[i]));
   end

   // wr_addr != 0 keeps r0 reads at zero even on a bypass hit
   assign byp_ok = BYPASS && rst_n && wr_en && (wr_addr != 5'd0);
   assign hit_a  = byp_ok && (rd_addr_a == wr_addr);
   assign hit_b  = byp_ok && (rd_addr_b == wr_addr);

   assign rd_data_a = hit_a ? wr_data : mux_a;
   assign rd_data_b = hit_b ? wr_data : mux_b;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: a bypassing and a non-bypassing instance share stimulus;
// expected read data is queued from a reference model and drained after each sample point.

module tb_reg_file_32x32;

   logic        clk, rst_n, wr_en;
   logic [4:0]  wr_addr, rd_addr_a, rd_addr_b;
   logic [31:0] wr_data;
   logic [31:0] rd_a1, rd_b1, rd_a0, rd_b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          port;   // 0: a/bypass  1: b/bypass  2: a/no-bypass  3: b/no-bypass
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [32];

   reg_file_32x32 #(.DATA_W(32), .BYPASS(1'b1)) u_dut_byp (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a1), .rd_data_b(rd_b1));

   reg_file_32x32 #(.DATA_W(32), .BYPASS(1'b0)) u_dut_nobyp (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a0), .rd_data_b(rd_b0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
      if (!rst_n) return 32'h0;
      if (ra == 5'd0) return 32'h0;
      if (byp && wr_en && (wr_addr != 5'd0) && (ra == wr_addr)) return wr_data;
      return mdl[ra];
   endfunction

   task automatic push_all(input string tag);
      sb.push_back('{tag: {tag, ".a_byp"},   port: 0, val: exp_rd(rd_addr_a, 1'b1)});
      sb.push_back('{tag: {tag, ".b_byp"},   port: 1, val: exp_rd(rd_addr_b, 1'b1)});
      sb.push_back('{tag: {tag, ".a_nobyp"}, port: 2, val: exp_rd(rd_addr_a, 1'b0)});
      sb.push_back('{tag: {tag, ".b_nobyp"}, port: 3, val: exp_rd(rd_addr_b, 1'b0)});
   endtask

   task automatic drain();
      exp_t e;
      logic [31:0] got;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.port)
            0:       got = rd_a1;
            1:       got = rd_b1;
            2:       got = rd_a0;
            default: got = rd_b0;
         endcase
         chk(e.tag, got, e.val);
      end
   endtask

   // One clock: drive at negedge, check before the rising edge and again just after it
   task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input string tag);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
      #2;
      push_all({tag, ".pre"});
      drain();
      @(posedge clk);
      if (rst_n && we && (wa != 5'd0)) mdl[wa] = wd;
      #1;
      push_all({tag, ".post"});
      drain();
   endtask

   initial begin
      for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
      rd_addr_a = 5'd3; rd_addr_b = 5'd31;
      #12;
      push_all("reset_state");
      drain();
      @(negedge clk);
      rst_n = 1'b1;

      // async reset mid-cycle, with a write to r5 pending
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, "rst_wr");
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
      #1;
      push_all("rst_pre");
      drain();
      #1 rst_n = 1'b0;
      for (int r = 0; r < 32; r++) mdl[r] = 32'h0;
      #1;
      push_all("rst_async");
      drain();
      @(posedge clk);
      #1;
      push_all("rst_held");
      drain();
      @(negedge clk);
      wr_en = 1'b0;
      #1 rst_n = 1'b1;
      #1;
      push_all("rst_release");
      drain();
      cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, "rst_after");

      // fill r1..r31 with their index, then sweep both ports
      for (int i = 1; i < 32; i++)
         cyc(1'b1, 5'(i), 32'(i), 5'(i), 5'(32 - i), "fill");
      for (int i = 0; i < 32; i++)
         cyc(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "sweep");

      // r0 write attempt
      cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "r0_wr");
      cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, "r0_rd");

      // bypass vs. no bypass on r7
      cyc(1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0, "byp_init");
      cyc(1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, "byp_hit");
      cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "byp_after");

      // write enable low: r9 must hold, no bypass; also X address while idle
      for (int i = 0; i < 3; i++)
         cyc(1'b0, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, "wen_low");
      cyc(1'b0, 5'bxxxxx, 32'hFFFF0000, 5'd9, 5'd10, "wen_xaddr");
      cyc(1'b0, 5'd0, 32'h0, 5'd11, 5'd12, "xaddr_after");

      // back-to-back writes to one address
      cyc(1'b1, 5'd12, 32'hCAFE0001, 5'd12, 5'd13, "b2b_1");
      cyc(1'b1, 5'd12, 32'hCAFE0002, 5'd12, 5'd12, "b2b_2");
      cyc(1'b0, 5'd0, 32'h0, 5'd12, 5'd13, "b2b_rd");

      // walking one in r31, walking zero in r16
      for (int k = 0; k < 32; k++) begin
         cyc(1'b1, 5'd31, 32'h1 << k, 5'd31, 5'd16, "walk1");
         cyc(1'b1, 5'd16, ~(32'h1 << k), 5'd31, 5'd16, "walk0");
      end
      cyc(1'b0, 5'd0, 32'h0, 5'd31, 5'd16, "walk_final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
